sequence_checker: RTL



---
 rtl/sequence_checker.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - game controller: replays the generator sequence, then checks player presses
// Optional press timeout in IN_WAIT is built when SEQUENCE_CHECKER_TIMEOUT_EN is defined.
module sequence_checker #(
  parameter int MAX_LEVEL      = 16,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] buttons,
  input  logic [3:0] seq,
  output logic       gen_randomize,
  output logic       gen_start_over,
  output logic       gen_next,
  output logic [3:0] lights,
  output logic [7:0] level,
  output logic       fail,
  output logic       win
);

  localparam int SG_MAX  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (SG_MAX > TIMEOUT_CYCLES) ? SG_MAX : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SHOW_END  = CW'(SHOW_CYCLES);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [7:0] MAX_LVL = 8'(MAX_LEVEL);

  typedef enum logic [3:0] {
    IDLE,
    SEED,
    SHOW_GAP,
    SHOW_SETTLE,
    SHOW_ON,
    SHOW_OFF,
    IN_SETTLE,
    IN_WAIT,
    FAIL_ST,
    WIN_ST
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    idx;
  logic [7:0]    idx_inc;

  assign idx_inc = idx + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= 8'd0;
      level          <= 8'd0;
      lights         <= 4'b0000;
      fail           <= 1'b0;
      win            <= 1'b0;
      gen_randomize  <= 1'b0;
      gen_start_over <= 1'b0;
      gen_next       <= 1'b0;
    end else begin
      gen_randomize  <= 1'b0;
      gen_start_over <= 1'b0;
      gen_next       <= 1'b0;

      case (state)
        IDLE, FAIL_ST: begin
          if (start) begin
            gen_randomize <= 1'b1;
            lights        <= 4'b0000;
            cnt           <= '0;
            state         <= SEED;
          end
        end

        SEED: begin
          level <= 8'd1;
          fail  <= 1'b0;
          win   <= 1'b0;
          idx   <= 8'd0;
          cnt   <= '0;
          state <= SHOW_GAP;
        end

        SHOW_GAP: begin
          lights <= 4'b0000;
          if (cnt == GAP_LAST) begin
            gen_start_over <= 1'b1;
            idx            <= 8'd0;
            cnt            <= '0;
            state          <= SHOW_SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHOW_SETTLE: begin
          cnt   <= '0;
          state <= SHOW_ON;
        end

        // First edge here is the earliest safe sample of seq after the strobe.
        SHOW_ON: begin
          if (cnt == SHOW_END) begin
            lights <= 4'b0000;
            cnt    <= '0;
            state  <= SHOW_OFF;
          end else begin
            lights <= seq;
            cnt    <= cnt + 1'b1;
          end
        end

        SHOW_OFF: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (idx_inc == level) begin
              gen_start_over <= 1'b1;
              idx            <= 8'd0;
              state          <= IN_SETTLE;
            end else begin
              idx      <= idx_inc;
              gen_next <= 1'b1;
              state    <= SHOW_SETTLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        IN_SETTLE: begin
          cnt   <= '0;
          state <= IN_WAIT;
        end

        // A press always takes priority over a timeout expiring on the same edge.
        IN_WAIT: begin
          if (|buttons) begin
            cnt <= '0;
            if (buttons != seq) begin
              fail   <= 1'b1;
              lights <= 4'b1111;
              state  <= FAIL_ST;
            end else if (idx_inc != level) begin
              idx      <= idx_inc;
              gen_next <= 1'b1;
              state    <= IN_SETTLE;
            end else if (level == MAX_LVL) begin
              win    <= 1'b1;
              lights <= 4'b0101;
              state  <= WIN_ST;
            end else begin
              level <= level + 8'd1;
              idx   <= 8'd0;
              state <= SHOW_GAP;
            end
          end
`ifdef SEQUENCE_CHECKER_TIMEOUT_EN
          else if (cnt == TIMEOUT_LAST) begin
            cnt    <= '0;
            fail   <= 1'b1;
            lights <= 4'b1111;
            state  <= FAIL_ST;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end

        WIN_ST: begin
          if (start) begin
            gen_randomize <= 1'b1;
            lights        <= 4'b0000;
            cnt           <= '0;
            state         <= SEED;
          end else if (cnt == SHOW_LAST) begin
            cnt    <= '0;
            lights <= ~lights;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
